prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Streaming program loader: fills a program memory from a byte stream, verifies a
// trailing 8-bit checksum and releases the CPU hold only after a verified load.
module prog_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] program_byte,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   load_count,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          sum_q;
    logic [DATA_W-1:0]   checksum_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                clear_c;
    logic                push_c;
    logic                latch_c;
    logic [7:0]          total_c;

    // Next-state and datapath strobes
    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        push_c  = 1'b0;
        latch_c = 1'b0;
        total_c = sum_q + 8'(checksum_q);
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LOAD;
                    clear_c = 1'b1;
                end
            end
            LOAD: begin
                if (byte_valid && byte_ready) begin
                    if (byte_last) begin
                        latch_c = 1'b1;
                        state_d = CHECK;
                    end else if (load_count == FULL) begin
                        state_d = ERR;
                    end else begin
                        push_c = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = (total_c == 8'd0) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, status outputs and session counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            load_count <= '0;
            addr_q     <= '0;
            sum_q      <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_ready <= (state_d == LOAD);
            cpu_hold   <= (state_d != DONE);
            done       <= (state_d == DONE);
            err        <= (state_d == ERR);
            if (clear_c) begin
                load_count <= '0;
                addr_q     <= '0;
                sum_q      <= '0;
            end
            if (push_c) begin
                // addr wraps to 0 naturally once the last location is written
                load_count <= load_count + (ADDR_W+1)'(1);
                addr_q     <= addr_q + ADDR_W'(1);
                sum_q      <= sum_q + 8'(byte_in);
            end
            if (latch_c) begin
                checksum_q <= byte_in;
            end
        end
    end

    // Program memory is deliberately left unreset
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[addr_q] <= byte_in;
        end
    end

    assign program_byte = mem[PC];

endmodule
